// File: rtl/insn_prefetch_queue.sv
// insn_prefetch_queue
//
// Instruction prefetcher between the core fetch port and SimRAM's read port.
// It owns the sequential fetch PC and issues at most one word read per cycle
// whenever buffer credit exists. Each returned word is tagged with its
// address and queued for decode. A redirect reloads the PC, flushes the
// queue and discards the read that is still in flight.
//
// Handshake: insn_valid/insn_ready follow strict valid/ready rules. An entry
// moves to decode on a cycle where both are high. While insn_valid is high
// and insn_ready is low, insn_data and insn_addr hold their values. The
// prefetcher never withdraws a valid entry except through a redirect or a
// reset.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rst_addr       fetch word address loaded during reset (PC = {rst_addr,2'b00})
//   halt           block new reads; the read in flight still completes
//   redirect       load redirect_addr into the PC and flush the queue
//   redirect_addr  new PC; bits [1:0] are forced to zero
//   ram_rd_en      SimRAM read request
//   ram_rd_addr    SimRAM read address (word aligned)
//   ram_rd_data    SimRAM read data, one cycle after ram_rd_en
//   insn_valid     head entry valid
//   insn_data      head instruction word
//   insn_addr      head instruction address
//   insn_ready     decode accepts the head entry
//   fetch_pc       next address to be requested
module insn_prefetch_queue #(
  parameter int DATA_SIZE  = 4,
  parameter int DATA_WIDTH = DATA_SIZE * 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  insn_valid,
  output logic [DATA_WIDTH-1:0] insn_data,
  output logic [ADDR_WIDTH-1:0] insn_addr,
  input  logic                  insn_ready,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]           DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(DATA_SIZE);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [CW-1:0]         count_q;

  logic [CW:0]           occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  // Low address bits of a redirect target are discarded.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_addr[1:0];
  assign redirect_pc = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};

  // Credit covers both queued words and the word still on its way back, so
  // a response always finds a free slot even when decode is stalled.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q);

  // rst_n gates the request so nothing is asked of SimRAM while reset is held.
  assign issue = rst_n && !halt && !redirect && (occupancy < DEPTH_OCC);

  // A redirect kills the response arriving this cycle and ignores any pop.
  assign push = inflight_q && !redirect;
  assign pop  = (count_q != '0) && insn_ready && !redirect;

  assign ram_rd_en   = issue;
  assign ram_rd_addr = pc_q;
  assign fetch_pc    = pc_q;

  assign insn_valid = (count_q != '0);
  assign insn_data  = data_mem[rptr_q];
  assign insn_addr  = addr_mem[rptr_q];

  // Fetch PC and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= {rst_addr, 2'b00};
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_addr_q <= pc_q;
      end
      if (redirect) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

  // Queue pointers and occupancy. A flush rewinds both pointers so the next
  // push lands at the slot the read side will present first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (push) begin
      data_mem[wptr_q] <= ram_rd_data;
      addr_mem[wptr_q] <= inflight_addr_q;
    end
  end

endmodule

// File: tb/tb_insn_prefetch_queue.sv
module tb_insn_prefetch_queue;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-3:0] rst_addr;
  logic          halt;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          insn_valid;
  logic [DW-1:0] insn_data;
  logic [AW-1:0] insn_addr;
  logic          insn_ready;
  logic [AW-1:0] fetch_pc;

  insn_prefetch_queue #(
    .DATA_SIZE (4),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_addr     (rst_addr),
    .halt         (halt),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .insn_valid   (insn_valid),
    .insn_data    (insn_data),
    .insn_addr    (insn_addr),
    .insn_ready   (insn_ready),
    .fetch_pc     (fetch_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM contents: word i holds 0xA5000000 | i.
  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 32'hA500_0000 | {26'h0, a[7:2]};
  endfunction

  always @(posedge clk) begin
    ram_rd_data <= ram_rd_en ? word_at(ram_rd_addr) : 32'hDEAD_BEEF;
  end

  // Reference model: queue of word addresses that decode will see, plus the
  // single outstanding read.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] m_pc;
  bit            m_inf;
  logic [AW-1:0] m_inf_addr;

  function automatic bit m_issue();
    return rst_n && !halt && !redirect && ((exp_q.size() + int'(m_inf)) < DEPTH);
  endfunction

  initial begin
    bit iss;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_inf = 1'b0;
        m_pc  = {rst_addr, 2'b00};
      end else begin
        iss = m_issue();
        if (redirect) begin
          exp_q.delete();
          m_inf = 1'b0;
          m_pc  = {redirect_addr[7:2], 2'b00};
        end else begin
          if (exp_q.size() != 0 && insn_ready) void'(exp_q.pop_front());
          if (m_inf) exp_q.push_back(m_inf_addr);
          m_inf      = iss;
          m_inf_addr = m_pc;
          if (iss) m_pc = m_pc + 8'd4;
        end
      end
    end
  end

  // Compare process: every negedge, outputs against the model.
  initial begin
    bit en;
    forever begin
      @(negedge clk);
      en = m_issue();
      chk("m_ram_rd_en", ram_rd_en, en);
      if (en) chk("m_ram_rd_addr", ram_rd_addr, m_pc);
      chk("m_fetch_pc", fetch_pc, m_pc);
      chk("m_insn_valid", insn_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("m_insn_addr", insn_addr, exp_q[0]);
        chk("m_insn_data", insn_data, word_at(exp_q[0]));
      end
    end
  end

  // Driver tasks: inputs change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_reset(input logic [AW-3:0] a, input logic rdy);
    step(1);
    rst_n      = 1'b0;
    rst_addr   = a;
    insn_ready = rdy;
    step(2);
    rst_n = 1'b1;
  endtask

  logic [AW-1:0] wrap_seq [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};

  initial begin
    int n;
    rst_n         = 1'b0;
    rst_addr      = 6'h04;
    halt          = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    insn_ready    = 1'b1;

    // Reset values
    step(2);
    @(negedge clk);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_insn_data", insn_data, 0);
    chk("rst_insn_addr", insn_addr, 0);
    chk("rst_fetch_pc", fetch_pc, 8'h10);

    // Streaming from reset, decode always ready
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_c0_en", ram_rd_en, 1);
    chk("s_c0_addr", ram_rd_addr, 8'h10);
    chk("s_c0_valid", insn_valid, 0);
    @(negedge clk);
    chk("s_c1_addr", ram_rd_addr, 8'h14);
    chk("s_c1_valid", insn_valid, 0);
    @(negedge clk);
    chk("s_c2_addr", ram_rd_addr, 8'h18);
    chk("s_c2_valid", insn_valid, 1);
    chk("s_c2_insn_addr", insn_addr, 8'h10);
    chk("s_c2_insn_data", insn_data, 32'hA500_0004);
    @(negedge clk);
    chk("s_c3_insn_addr", insn_addr, 8'h14);

    // Decode stalled from reset: exactly DEPTH reads
    start_reset(6'h04, 1'b0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_rd_en) n++;
    end
    chk("full_issue_count", n, 4);
    chk("full_valid", insn_valid, 1);
    chk("full_head_hold", insn_addr, 8'h10);
    step(1);
    insn_ready = 1'b1;
    @(negedge clk);
    chk("drain_k0_en", ram_rd_en, 0);
    chk("drain_k0_addr", insn_addr, 8'h10);
    @(negedge clk);
    chk("drain_k1_en", ram_rd_en, 1);
    chk("drain_k1_rd_addr", ram_rd_addr, 8'h20);
    chk("drain_k1_addr", insn_addr, 8'h14);
    @(negedge clk);
    chk("drain_k2_addr", insn_addr, 8'h18);
    @(negedge clk);
    chk("drain_k3_addr", insn_addr, 8'h1C);
    @(negedge clk);
    chk("drain_k4_addr", insn_addr, 8'h20);

    // Redirect with the queue at full credit and a read in flight
    start_reset(6'h04, 1'b0);
    step(4);
    redirect      = 1'b1;
    redirect_addr = 8'h41;
    @(negedge clk);
    chk("rd_R_en", ram_rd_en, 0);
    chk("rd_R_valid", insn_valid, 1);
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("rd_R1_valid", insn_valid, 0);
    chk("rd_R1_rd_addr", ram_rd_addr, 8'h40);
    @(negedge clk);
    chk("rd_R2_valid", insn_valid, 0);
    @(negedge clk);
    chk("rd_R3_valid", insn_valid, 1);
    chk("rd_R3_addr", insn_addr, 8'h40);
    chk("rd_R3_data", insn_data, 32'hA500_0010);

    // PC wrap, with a pop attempted in the redirect cycle
    step(1);
    insn_ready    = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 8'hF8;
    step(1);
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("wrap_R1_valid", insn_valid, 0);
      if (i < 4) chk("wrap_rd_addr", ram_rd_addr, wrap_seq[i]);
      if (i >= 2) chk("wrap_insn_addr", insn_addr, wrap_seq[i-2]);
    end

    // Halt one cycle after an issue
    step(1);
    redirect      = 1'b1;
    redirect_addr = 8'h80;
    step(1);
    redirect = 1'b0;
    step(1);
    halt = 1'b1;
    @(negedge clk);
    chk("halt_R2_en", ram_rd_en, 0);
    @(negedge clk);
    chk("halt_R3_valid", insn_valid, 1);
    chk("halt_R3_addr", insn_addr, 8'h80);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_rd_en) n++;
    end
    chk("halt_no_issue", n, 0);
    chk("halt_drained", insn_valid, 0);
    step(1);
    halt = 1'b0;
    @(negedge clk);
    chk("halt_resume_en", ram_rd_en, 1);
    chk("halt_resume_addr", ram_rd_addr, 8'h84);
    @(negedge clk);
    @(negedge clk);
    chk("halt_resume_insn", insn_addr, 8'h84);

    // Asynchronous reset between clock edges
    step(3);
    chk("areset_pre_valid", insn_valid, 1);
    #1;
    rst_addr = 6'h20;
    rst_n    = 1'b0;
    #1;
    chk("areset_en", ram_rd_en, 0);
    chk("areset_valid", insn_valid, 0);
    chk("areset_pc", fetch_pc, 8'h80);
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset_restart_addr", ram_rd_addr, 8'h80);
    chk("areset_restart_valid", insn_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("areset_first_insn", insn_addr, 8'h80);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/insn_prefetch_queue.md
Name: insn_prefetch_queue

Overview:
Instruction prefetcher sitting between the core's fetch port and SimRAM's read port. It owns the sequential fetch PC and issues one word read per cycle while buffer credit exists. It tags each returned word with its address and presents it to the core's decode stage through a valid/ready FIFO. Redirects (branch, debug PC write) flush the buffer and discard in-flight reads.

Parameters:
DATA_SIZE, 4, instruction size in bytes; PC step.
DATA_WIDTH, DATA_SIZE*8, instruction width.
ADDR_WIDTH, 8, byte address width.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rst_addr  in  ADDR_WIDTH-2  reset fetch word address; PC = {rst_addr, 2'b00}
halt  in  1  stop issuing new reads (debug); in-flight read still completes
redirect  in  1  load new PC, flush queue
redirect_addr  in  ADDR_WIDTH  new PC; bits [1:0] ignored (forced 0)
ram_rd_en  out  1  read request to SimRAM
ram_rd_addr  out  ADDR_WIDTH  read address (word aligned)
ram_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after ram_rd_en
insn_valid  out  1  head entry valid
insn_data  out  DATA_WIDTH  head instruction
insn_addr  out  ADDR_WIDTH  head instruction address
insn_ready  in  1  decode accepts head
fetch_pc  out  ADDR_WIDTH  next address to be requested (debug/DPI visibility)

Behaviour:
- Reset (rst_n low, async): fetch_pc = {rst_addr,2'b00}, FIFO empty, in-flight flag 0, ram_rd_en=0, insn_valid=0, insn_data=0, insn_addr=0. rst_addr sampled while reset asserted.
- Credit: issue allowed when (count + inflight) < DEPTH, halt=0, redirect=0. On issue: ram_rd_en=1, ram_rd_addr=fetch_pc (combinational from the register), fetch_pc += DATA_SIZE mod 2^ADDR_WIDTH (0xFC -> 0x00 wraps).
- Response: a read issued in cycle N returns ram_rd_data in N+1. In N+1 it is pushed with its address (held in an in-flight address register) unless killed. At most one read in flight per cycle; back-to-back issue every cycle is allowed (throughput 1 word/cycle).
- Pop: insn_valid && insn_ready removes the head. Simultaneous push and pop is allowed at any count, including full (credit guarantees no overflow) and empty (pushed word is not bypassed; visible next cycle; zero-cycle bypass forbidden).
- insn_data/insn_addr are registered FIFO outputs; they hold their value while insn_valid && !insn_ready.
- Redirect (cycle R): fetch_pc <= {redirect_addr[ADDR_WIDTH-1:2],2'b00}; FIFO count <= 0; any read issued in R-1 is killed (its data in R is dropped). No read is issued in R. The first read of the new address is issued in R+1; the first valid instruction appears in R+3 (insn_valid high in R+3). Redirect wins over a pop or push in the same cycle; a pop in R is ignored and decode sees insn_valid=0 in R+1.
- Halt: blocks new issue only. The in-flight read completes and is pushed; the queue drains normally via pop. Deasserting halt resumes from fetch_pc. A redirect during halt updates fetch_pc.
- Reset mid-operation: all state returns to reset values immediately; a pending RAM response is ignored.
- Counters: count is log2(DEPTH)+1 bits; read/write pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset with rst_addr=6'h04, insn_ready=1, RAM word[i]=i: ram_rd_addr sequence 0x10,0x14,0x18 on consecutive cycles; insn_valid first high 2 cycles after reset release with insn_addr=0x10, then 1 instruction per cycle.
- insn_ready=0 from reset: exactly DEPTH=4 reads issued (0x10..0x1C), ram_rd_en then stays 0, head holds 0x10. Raising insn_ready gives 4 pops plus resumed issue at 0x20 with no gap larger than 2 cycles.
- Redirect to 0x41 while the queue is full and a read is in flight: the stale response is dropped, the next issued address is 0x40, and insn_valid=0 until R+3, when insn_addr=0x40.
- PC wrap: redirect to 0xF8 gives fetch addresses 0xF8, 0xFC, 0x00, 0x04; insn_addr follows in the same order.
- Halt asserted one cycle after an issue: the in-flight word is still delivered and ram_rd_en stays 0 for the whole halt. Release resumes at the next sequential address with no duplicated or skipped insn_addr.
- Async reset asserted mid-stream between clock edges: insn_valid and ram_rd_en fall immediately. After release, fetch restarts at {rst_addr,2'b00}.
